tbus_reader: RTL

Receive-side controller for a shared tristate bus built from inverting tristate buffer cells, one bank of `WIDTH` cells per driver. The block arbitrates among `NDRV` requesting drivers and drives their one-hot enable lines. It enforces break-before-make turnaround between drivers, samples the bus, re-inverts the data, and presents each word on a valid/ready output port with the source ID. It sits on the bus-owner side of the SoC fabric, opposite the tristate driver banks.

---
 rtl/tbus_if.sv | 26 ++
 rtl/tbus_reader.sv | 110 +++++++++++
 2 files changed

// File: rtl/tbus_if.sv
// Bus-side and output-side signal bundle for the tristate bus reader.
// The master modport belongs to the reader; the slave modport to drivers and the downstream sink.
interface tbus_if #(
  parameter int WIDTH = 8,
  parameter int NDRV  = 4,
  parameter int IDW   = $clog2(NDRV)
);
  logic [NDRV-1:0]  req;
  logic [NDRV-1:0]  en;
  logic [WIDTH-1:0] bus_y;
  logic [NDRV-1:0]  ack;
  logic [WIDTH-1:0] out_data;
  logic [IDW-1:0]   out_id;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  req, bus_y, out_ready,
    output en, ack, out_data, out_id, out_valid
  );

  modport slave (
    output req, bus_y, out_ready,
    input  en, ack, out_data, out_id, out_valid
  );
endinterface

// File: rtl/tbus_reader.sv
// Round-robin reader for a shared inverting tristate bus with break-before-make turnaround.
// Captured words are re-inverted and presented on a valid/ready port tagged with the source ID.
module tbus_reader #(
  parameter int WIDTH = 8,
  parameter int NDRV  = 4,
  parameter int IDW   = $clog2(NDRV)
) (
  input logic    clk,
  input logic    rst_n,
  tbus_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, TURN} state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   g, g_next;
  logic [IDW-1:0]   ptr, ptr_next;
  logic [IDW-1:0]   cand, idx;
  logic             found;
  logic [NDRV-1:0]  en_q, en_next;
  logic [NDRV-1:0]  ack_q, ack_next;
  logic [WIDTH-1:0] data_q, data_next;
  logic [IDW-1:0]   id_q, id_next;
  logic             valid_q, valid_next;

  // First requester at or after ptr, wrapping at NDRV-1.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NDRV; i++) begin
      idx = IDW'((32'(ptr) + i) % NDRV);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    g_next     = g;
    ptr_next   = ptr;
    en_next    = '0;
    ack_next   = '0;
    data_next  = data_q;
    id_next    = id_q;
    valid_next = valid_q;

    if (valid_q && bus.out_ready) valid_next = 1'b0;

    // en/ack are computed for the state being entered so both leave the block registered.
    case (state)
      IDLE: begin
        if (found && (!valid_q || bus.out_ready)) begin
          g_next        = cand;
          en_next[cand] = 1'b1;
          state_next    = DRIVE;
        end
      end
      DRIVE: begin
        en_next[g] = 1'b1;
        state_next = SAMPLE;
      end
      SAMPLE: begin
        ack_next[g] = 1'b1;
        data_next   = ~bus.bus_y;
        id_next     = g;
        valid_next  = 1'b1;
        ptr_next    = (g == IDW'(NDRV - 1)) ? '0 : g + 1'b1;
        state_next  = TURN;
      end
      TURN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      g       <= '0;
      ptr     <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      g       <= g_next;
      ptr     <= ptr_next;
      en_q    <= en_next;
      ack_q   <= ack_next;
      data_q  <= data_next;
      id_q    <= id_next;
      valid_q <= valid_next;
    end
  end

  assign bus.en        = en_q;
  assign bus.ack       = ack_q;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.out_valid = valid_q;

endmodule
